alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational `alu` instance between two requesters (port 0 and port 1) through valid/ready handshakes. A requester is granted, its operands and function code are latched, the result and zero flag are registered, and the result is returned on that requester's response channel. It sits between two issuing units (for example, the main datapath and a multi-cycle helper) and the single ALU, so the ALU never needs to be duplicated.

## Interface
- WIDTH, 32, operand/result width.
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accept; one-hot or zero.
- req_f0, req_f1  in  4  function code per port.
- req_a0, req_b0, req_a1, req_b1  in  WIDTH  operands per port.
- rsp_valid  out  2  per-port response valid; one-hot or zero.
- rsp_ready  in  2  per-port response accept.
- rsp_y  out  WIDTH  result, shared by both ports, qualified by rsp_valid.
- rsp_z  out  1  zero flag (rsp_y == 0), qualified by rsp_valid.
- busy  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise, grant one port. If only one port is valid, grant it. If both are valid, grant the port named by the priority pointer `prio`.
  - req_ready[g] is high combinationally in IDLE only, for the granted port g only.
  - On the req_valid[g] && req_ready[g] handshake, latch f, a, b and g, then go to EXEC.
- EXEC:
  - The latched operands drive the `alu`.
  - Capture y into rsp_y and z into rsp_z, then go to RESP.
- RESP:
  - rsp_valid[g] is high. rsp_y and rsp_z stay stable until rsp_ready[g] is seen.
  - On rsp_ready[g], go to IDLE and set `prio` to the port other than g.
  - rsp_ready on the non-granted port is ignored.
- Function codes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 5 SRL (a >> b), 6 SUB, 7 SLTU, 12 NOR.
  - All other codes produce y = 0 and z = 1.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SRL uses the full value of b; b >= WIDTH gives 0.
  - SLTU is an unsigned compare; the 1/0 result is zero-extended.
- Requests are never queued. A port that is not granted keeps req_valid asserted and retries in the next IDLE cycle.

## Timing
- Reset values: state = IDLE, prio = 0, req_ready = 0 while rstn is low, rsp_valid = 0, rsp_y = 0, rsp_z = 0, busy = 0.
- Latency: handshake in cycle N gives rsp_valid in cycle N+2.
- Minimum spacing is 3 cycles per operation. A response accepted in cycle M allows the next accept in cycle M+1.
- Simultaneous requests after reset: port 0 wins. Under continuous contention the ports strictly alternate.
- rsp_ready held low: the block stalls in RESP indefinitely; req_ready stays 0 for both ports.
- Reset asserted mid-operation: the in-flight operation is discarded immediately and no response is produced after reset is released.
- Operand inputs are sampled only in the accept cycle. Later changes on the request inputs do not affect the in-flight result.

## Configuration
- `ALU_SHARE_STATS_EN` defined:
  - Adds two outputs, cnt0 and cnt1 (16 bits each).
  - Each counts completed response handshakes for its port.
  - Counters saturate at 0xFFFF and reset to 0.
- `ALU_SHARE_STATS_EN` undefined: the counters and their ports do not exist.
- Core behaviour is identical either way.

## Structure
- Shared package `alu_share_pkg` holds:
  - the state encodings (IDLE = 0, EXEC = 1, RESP = 2, 2-bit);
  - the function-code localparams (F_AND, F_OR, F_ADD, F_XOR, F_SRL, F_SUB, F_SLTU, F_NOR).
- One sub-module: the existing `alu`, instanced with WIDTH passed through and fed from the latched operand registers.
- The grant logic is a few lines of inline combinational logic; it is not a separate module.

## Test plan
- Reset then idle: rstn low → all outputs 0. Release with no requests → state stays IDLE, busy = 0.
- Single request: port 0, f = 2, a = 5, b = 7, accepted in cycle N → rsp_valid = 2'b01 in cycle N+2, rsp_y = 12, rsp_z = 0.
- Contention: both ports held valid (port 0: f = 6, a = 3, b = 3; port 1: f = 7, a = 1, b = 2) with rsp_ready = 1 → port 0 first (y = 0, z = 1), then port 1 (y = 1), then port 0 again.
- Backpressure: rsp_ready = 0 for 5 cycles in RESP → rsp_y stable, req_ready = 0. Raise rsp_ready → IDLE in the next cycle.
- Edge operations: f = 5 with b = 40 → y = 0. f = 9 → y = 0, z = 1. f = 12 with a = b = 0 → y = all ones.
- Reset in EXEC: assert rstn low while in EXEC, then release → no rsp_valid, prio = 0, next simultaneous request goes to port 0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: FSM state encoding,
// ALU function codes and a one-hot helper for port selects.
package alu_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] F_AND  = 4'd0;
   localparam logic [3:0] F_OR   = 4'd1;
   localparam logic [3:0] F_ADD  = 4'd2;
   localparam logic [3:0] F_XOR  = 4'd3;
   localparam logic [3:0] F_SRL  = 4'd5;
   localparam logic [3:0] F_SUB  = 4'd6;
   localparam logic [3:0] F_SLTU = 4'd7;
   localparam logic [3:0] F_NOR  = 4'd12;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both requesters; unknown function codes
// yield zero so the zero flag reads one.
module alu
   import alu_share_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       f,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             z
);

   always_comb begin
      // NOTE: y gets a default before the case so every path assigns it and no latch is inferred.
      y = '0;
      case (f)
         F_AND:   y = a & b;
         F_OR:    y = a | b;
         F_ADD:   y = a + b;
         F_XOR:   y = a ^ b;
         F_SRL:   y = a >> b;  // full-width shift amount: b >= WIDTH clears the result
         F_SUB:   y = a - b;
         F_SLTU:  y = {{(WIDTH-1){1'b0}}, (a < b)};
         F_NOR:   y = ~(a | b);
         default: y = '0;
      endcase
      z = (y == '0);
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port valid/ready arbiter in front of one shared ALU (IDLE/EXEC/RESP).
// Define ALU_SHARE_STATS_EN to add saturating per-port completion counters cnt0/cnt1.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [3:0]       req_f0,
   input  logic [3:0]       req_f1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_z,
   output logic             busy
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
`endif
);

   state_t           state, state_nx;
   logic             prio;
   logic             gnt;
   logic             g_q;
   logic             accept;
   logic             rsp_done;
   logic [3:0]       f_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] alu_y;
   logic             alu_z;

   // Only contention consults the priority pointer.
   assign gnt      = (req_valid == 2'b11) ? prio : req_valid[1];
   assign accept   = (state == IDLE) && (req_valid != 2'b00);
   assign rsp_done = (state == RESP) && rsp_ready[g_q];
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx  = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      case (state)
         IDLE: begin
            if (rstn && (req_valid != 2'b00)) begin
               req_ready = port_onehot(gnt);
               state_nx  = EXEC;
            end
         end
         EXEC: state_nx = RESP;
         RESP: begin
            rsp_valid = port_onehot(g_q);
            if (rsp_ready[g_q]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         prio  <= 1'b0;
         g_q   <= 1'b0;
         rsp_y <= '0;
         rsp_z <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_nx;
         if (accept) g_q <= gnt;
         if (state == EXEC) begin
            rsp_y <= alu_y;
            rsp_z <= alu_z;
         end
         if (rsp_done) prio <= ~g_q;
      end
   end

   // NOTE: operand registers are pure datapath, always written before use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         f_q <= gnt ? req_f1 : req_f0;
         a_q <= gnt ? req_a1 : req_a0;
         b_q <= gnt ? req_b1 : req_b0;
      end
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .f (f_q),
      .a (a_q),
      .b (b_q),
      .y (alu_y),
      .z (alu_z)
   );

`ifdef ALU_SHARE_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (rsp_done) begin
         if (!g_q && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
         if ( g_q && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: reset, vector table, reset in EXEC,
// contention, backpressure and randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [3:0]    req_f0, req_f1;
   logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
   logic [W-1:0]  rsp_y;
   logic          rsp_z;
   logic          busy;
`ifdef ALU_SHARE_STATS_EN
   logic [15:0]   cnt0, cnt1;
`endif

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_f0    (req_f0),
      .req_f1    (req_f1),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_z     (rsp_z),
      .busy      (busy)
`ifdef ALU_SHARE_STATS_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1)
`endif
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic model_prio;
   int   model_cnt [2];

   typedef struct {
      logic [1:0]   v;
      logic [3:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
      logic         z;
      int           stall;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU written straight from the function-code table.
   function automatic logic [W-1:0] ref_y(input logic [3:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (f)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return W'((64'(a) + 64'(b)) % (64'd1 << W));
         4'd3:  return a ^ b;
         4'd5:  return (b >= W) ? '0 : (a >> b[4:0]);
         4'd6:  return W'((64'(a) + (64'd1 << W) - 64'(b)) % (64'd1 << W));
         4'd7:  return (a < b) ? W'(1) : '0;
         4'd12: return ~(a | b);
         default: return '0;
      endcase
   endfunction

   function automatic logic ref_grant(input logic [1:0] v, input logic p);
      if (v[0] && v[1]) return p;
      else if (v[1])    return 1'b1;
      else              return 1'b0;
   endfunction

   task automatic set_port(input int p, input logic [3:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b);
      if (p == 0) begin
         req_f0 = f; req_a0 = a; req_b0 = b;
      end else begin
         req_f1 = f; req_a1 = a; req_b1 = b;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      model_prio   = 1'b0;
      model_cnt[0] = 0;
      model_cnt[1] = 0;
   endtask

   // Entered at posedge+1 with the DUT in IDLE and request operands already driven.
   // Returns at posedge+1 of the cycle after the response handshake.
   task automatic do_op(input logic [1:0] vmask, input int stall, input logic [W-1:0] exp_y,
                        input logic exp_z, input string tag);
      logic       g;
      logic [1:0] oh;
      g  = ref_grant(vmask, model_prio);
      oh = g ? 2'b10 : 2'b01;
      req_valid = vmask;
      rsp_ready = 2'b00;
      @(negedge clk);
      check($sformatf("%s req_ready", tag), W'(req_ready), W'(oh));
      check($sformatf("%s busy idle", tag), W'(busy), W'(0));
      tick;
      // Scramble request inputs: the in-flight result must not follow them.
      set_port(0, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      set_port(1, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      @(negedge clk);
      check($sformatf("%s rsp_valid exec", tag), W'(rsp_valid), W'(0));
      check($sformatf("%s busy exec", tag), W'(busy), W'(1));
      tick;
      @(negedge clk);
      check($sformatf("%s rsp_valid", tag), W'(rsp_valid), W'(oh));
      check($sformatf("%s rsp_y", tag), rsp_y, exp_y);
      check($sformatf("%s rsp_z", tag), W'(rsp_z), W'(exp_z));
      for (int s = 0; s < stall; s++) begin
         rsp_ready = ~oh;
         tick;
         @(negedge clk);
         check($sformatf("%s stall rsp_valid", tag), W'(rsp_valid), W'(oh));
         check($sformatf("%s stall rsp_y", tag), rsp_y, exp_y);
         check($sformatf("%s stall req_ready", tag), W'(req_ready), W'(0));
      end
      rsp_ready = oh;
      tick;
      rsp_ready = 2'b00;
      req_valid = 2'b00;
      model_prio = ~g;
      if (model_cnt[g] < 65535) model_cnt[g]++;
      check($sformatf("%s busy after", tag), W'(busy), W'(0));
      check($sformatf("%s rsp_valid after", tag), W'(rsp_valid), W'(0));
`ifdef ALU_SHARE_STATS_EN
      check($sformatf("%s cnt0", tag), W'(cnt0), W'(model_cnt[0]));
      check($sformatf("%s cnt1", tag), W'(cnt1), W'(model_cnt[1]));
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [15];
      logic g;
      logic [1:0] v;
      logic [3:0] fr [2];
      logic [W-1:0] ar [2], br [2];

      vecs[0]  = '{2'b01, 4'd2,  32'd5,          32'd7,          32'd12,         1'b0, 0};
      vecs[1]  = '{2'b10, 4'd0,  32'hF0F0_FFFF,  32'h0FF0_00F0,  32'h00F0_00F0,  1'b0, 0};
      vecs[2]  = '{2'b01, 4'd1,  32'h1200_0000,  32'h0000_0034,  32'h1200_0034,  1'b0, 0};
      vecs[3]  = '{2'b10, 4'd3,  32'hAAAA_AAAA,  32'hAAAA_AAAA,  32'h0,          1'b1, 0};
      vecs[4]  = '{2'b01, 4'd5,  32'h8000_0000,  32'd31,         32'h1,          1'b0, 0};
      vecs[5]  = '{2'b10, 4'd5,  32'hFFFF_FFFF,  32'd40,         32'h0,          1'b1, 5};
      vecs[6]  = '{2'b01, 4'd5,  32'hFFFF_FFFF,  32'd32,         32'h0,          1'b1, 0};
      vecs[7]  = '{2'b10, 4'd6,  32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 0};
      vecs[8]  = '{2'b01, 4'd2,  32'hFFFF_FFFF,  32'd1,          32'h0,          1'b1, 0};
      vecs[9]  = '{2'b10, 4'd7,  32'd1,          32'd2,          32'h1,          1'b0, 0};
      vecs[10] = '{2'b01, 4'd7,  32'hFFFF_FFFF,  32'd1,          32'h0,          1'b1, 0};
      vecs[11] = '{2'b10, 4'd12, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 0};
      vecs[12] = '{2'b01, 4'd9,  32'd5,          32'd3,          32'h0,          1'b1, 0};
      vecs[13] = '{2'b10, 4'd4,  32'd7,          32'd7,          32'h0,          1'b1, 2};
      vecs[14] = '{2'b01, 4'd15, 32'h1234_5678,  32'h9ABC_DEF0,  32'h0,          1'b1, 0};

      // Reset with both ports requesting: nothing may be accepted.
      rstn = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      set_port(0, 4'd2, 32'd1, 32'd1);
      set_port(1, 4'd2, 32'd1, 32'd1);
      #2;
      check("reset req_ready", W'(req_ready), W'(0));
      check("reset rsp_valid", W'(rsp_valid), W'(0));
      check("reset rsp_y", rsp_y, W'(0));
      check("reset rsp_z", W'(rsp_z), W'(0));
      check("reset busy", W'(busy), W'(0));
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick;
         check("idle busy", W'(busy), W'(0));
         check("idle req_ready", W'(req_ready), W'(0));
      end

      // Vector table: single-port operations with edge operands and backpressure.
      foreach (vecs[i]) begin
         set_port(vecs[i].v[1] ? 1 : 0, vecs[i].f, vecs[i].a, vecs[i].b);
         do_op(vecs[i].v, vecs[i].stall, vecs[i].y, vecs[i].z, $sformatf("vec%0d", i));
      end

      // Reset during EXEC discards the operation and restores port-0 priority.
      set_port(1, 4'd2, 32'd10, 32'd20);
      req_valid = 2'b10;
      @(negedge clk);
      check("rst_exec req_ready", W'(req_ready), W'(2'b10));
      tick;
      req_valid = 2'b00;
      check("rst_exec busy before", W'(busy), W'(1));
      rstn = 1'b0;
      #1;
      check("rst_exec busy", W'(busy), W'(0));
      check("rst_exec rsp_valid", W'(rsp_valid), W'(0));
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick;
         check("rst_exec no rsp", W'(rsp_valid), W'(0));
      end

      // Continuous contention: port 0 first, then strict alternation.
      for (int i = 0; i < 3; i++) begin
         set_port(0, 4'd6, 32'd3, 32'd3);
         set_port(1, 4'd7, 32'd1, 32'd2);
         if (i == 1) do_op(2'b11, 0, 32'd1, 1'b0, $sformatf("cont%0d", i));
         else        do_op(2'b11, 0, 32'd0, 1'b1, $sformatf("cont%0d", i));
      end

      // Randomized traffic against the reference model.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            req_valid = 2'b00;
            @(negedge clk);
            check("rand idle req_ready", W'(req_ready), W'(0));
            tick;
            check("rand idle busy", W'(busy), W'(0));
         end
         v = 2'($urandom_range(1, 3));
         for (int p = 0; p < 2; p++) begin
            fr[p] = 4'($urandom_range(0, 15));
            ar[p] = W'($urandom);
            br[p] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 40)) : W'($urandom);
            set_port(p, fr[p], ar[p], br[p]);
         end
         g = ref_grant(v, model_prio);
         do_op(v, $urandom_range(0, 3), ref_y(fr[g], ar[g], br[g]),
               (ref_y(fr[g], ar[g], br[g]) == '0), $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
